// File: rtl/excp_ctrl_pkg.sv
// Shared definitions for the machine-mode exception controller:
// bus widths, CSR addresses, cause codes, mstatus bit positions,
// FSM state encodings and the mstatus update helpers.
package excp_ctrl_pkg;

    localparam int REG_BUS      = 32;
    localparam int CSR_ADDR_BUS = 12;

    // CSR addresses
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_BUS-1:0] CSR_MCAUSE  = 12'h342;

    // Cause codes; CAUSE_NONE marks an MRET return (no trap cause latched)
    localparam logic [REG_BUS-1:0] CAUSE_NONE    = 32'h0000_0000;
    localparam logic [REG_BUS-1:0] CAUSE_EBREAK  = 32'h0000_0003;
    localparam logic [REG_BUS-1:0] CAUSE_ECALL   = 32'h0000_000B;
    localparam logic [REG_BUS-1:0] CAUSE_IRQ_EXT = 32'h8000_000B;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT    = 3;
    localparam int MSTATUS_MPIE_BIT   = 7;
    localparam int MSTATUS_MPP_LO_BIT = 11;
    localparam int MSTATUS_MPP_HI_BIT = 12;

    // FSM state encodings
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MSTATUS = 3'd3,
        ST_W_MRET    = 3'd4,
        ST_JUMP      = 3'd5
    } excp_state_e;

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- machine
    function automatic logic [REG_BUS-1:0] mstatus_on_trap(input logic [REG_BUS-1:0] m);
        logic [REG_BUS-1:0] r;
        r                                        = m;
        r[MSTATUS_MPIE_BIT]                      = m[MSTATUS_MIE_BIT];
        r[MSTATUS_MIE_BIT]                       = 1'b0;
        r[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = 2'b11;
        return r;
    endfunction

    // mstatus on MRET: MIE <- MPIE, MPIE <- 1
    function automatic logic [REG_BUS-1:0] mstatus_on_mret(input logic [REG_BUS-1:0] m);
        logic [REG_BUS-1:0] r;
        r                   = m;
        r[MSTATUS_MIE_BIT]  = m[MSTATUS_MPIE_BIT];
        r[MSTATUS_MPIE_BIT] = 1'b1;
        return r;
    endfunction

    // Force a redirect target onto a word boundary
    function automatic logic [REG_BUS-1:0] word_align(input logic [REG_BUS-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/excp_ctrl.sv
// Machine-mode exception controller. Accepts ECALL/EBREAK/MRET (and an
// external interrupt when built with EXCP_IRQ_EN), sequences the CSR
// writes one per cycle, then emits a one-cycle PC redirect while holding
// the pipeline for the whole sequence.
// Build option: define EXCP_IRQ_EN to add the irq_i port and interrupt path.
module excp_ctrl
    import excp_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ecall_i,
    input  logic                    ebreak_i,
    input  logic                    mret_i,
    input  logic [REG_BUS-1:0]      inst_addr_i,
`ifdef EXCP_IRQ_EN
    input  logic                    irq_i,
`endif
    input  logic [REG_BUS-1:0]      mtvec_i,
    input  logic [REG_BUS-1:0]      mepc_i,
    input  logic [REG_BUS-1:0]      mstatus_i,
    output logic                    excp_we_o,
    output logic [CSR_ADDR_BUS-1:0] excp_waddr_o,
    output logic [REG_BUS-1:0]      excp_wdata_o,
    output logic                    hold_o,
    output logic                    jump_o,
    output logic [REG_BUS-1:0]      jump_addr_o
);

    excp_state_e        state_q;
    excp_state_e        state_d;
    logic [REG_BUS-1:0] pc_q;
    logic [REG_BUS-1:0] cause_q;

    logic               irq_take_s;
    logic               trap_take_s;
    logic               mret_take_s;
    logic [REG_BUS-1:0] cause_sel_s;

    // Trigger arbitration: irq > ecall > ebreak > mret, cause selection
    always_comb begin
        irq_take_s = 1'b0;
`ifdef EXCP_IRQ_EN
        irq_take_s = irq_i & mstatus_i[MSTATUS_MIE_BIT];
`endif
        trap_take_s = irq_take_s | ecall_i | ebreak_i;
        mret_take_s = ~trap_take_s & mret_i;
        if (irq_take_s) begin
            cause_sel_s = CAUSE_IRQ_EXT;
        end else if (ecall_i) begin
            cause_sel_s = CAUSE_ECALL;
        end else if (ebreak_i) begin
            cause_sel_s = CAUSE_EBREAK;
        end else begin
            cause_sel_s = CAUSE_NONE;
        end
    end

    // State register plus PC/cause capture at acceptance in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 32'h0000_0000;
            cause_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && trap_take_s) begin
                pc_q    <= inst_addr_i;
                cause_q <= cause_sel_s;
            end else if (state_q == ST_IDLE && mret_take_s) begin
                pc_q    <= pc_q;
                cause_q <= CAUSE_NONE;
            end else begin
                pc_q    <= pc_q;
                cause_q <= cause_q;
            end
        end
    end

    // Next-state logic; triggers are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trap_take_s) begin
                    state_d = ST_W_MEPC;
                end else if (mret_take_s) begin
                    state_d = ST_W_MRET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_W_MEPC:    state_d = ST_W_MCAUSE;
            ST_W_MCAUSE:  state_d = ST_W_MSTATUS;
            ST_W_MSTATUS: state_d = ST_JUMP;
            ST_W_MRET:    state_d = ST_JUMP;
            ST_JUMP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode; address/data stay zero whenever no write is issued.
    // In IDLE the stall is combinational on the triggers, so it is also
    // qualified by rst_n to keep every output low while reset is asserted.
    always_comb begin
        excp_we_o    = 1'b0;
        excp_waddr_o = 12'h000;
        excp_wdata_o = 32'h0000_0000;
        hold_o       = 1'b0;
        jump_o       = 1'b0;
        jump_addr_o  = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                hold_o = rst_n & (trap_take_s | mret_take_s);
            end
            ST_W_MEPC: begin
                hold_o       = 1'b1;
                excp_we_o    = 1'b1;
                excp_waddr_o = CSR_MEPC;
                excp_wdata_o = pc_q;
            end
            ST_W_MCAUSE: begin
                hold_o       = 1'b1;
                excp_we_o    = 1'b1;
                excp_waddr_o = CSR_MCAUSE;
                excp_wdata_o = cause_q;
            end
            ST_W_MSTATUS: begin
                hold_o       = 1'b1;
                excp_we_o    = 1'b1;
                excp_waddr_o = CSR_MSTATUS;
                excp_wdata_o = mstatus_on_trap(mstatus_i);
            end
            ST_W_MRET: begin
                hold_o       = 1'b1;
                excp_we_o    = 1'b1;
                excp_waddr_o = CSR_MSTATUS;
                excp_wdata_o = mstatus_on_mret(mstatus_i);
            end
            ST_JUMP: begin
                hold_o = 1'b1;
                jump_o = 1'b1;
                if (cause_q == CAUSE_NONE) begin
                    jump_addr_o = word_align(mepc_i);
                end else begin
                    jump_addr_o = word_align(mtvec_i);
                end
            end
            default: begin
                hold_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl: each driven cycle pushes its expected
// output record to a scoreboard queue; a negedge monitor pops and compares.
// Define EXCP_IRQ_EN for both RTL and bench to exercise the interrupt path.
module tb_excp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ecall_i, ebreak_i, mret_i, irq_i;
    logic [31:0] inst_addr_i, mtvec_i, mepc_i, mstatus_i;
    logic        excp_we_o;
    logic [11:0] excp_waddr_o;
    logic [31:0] excp_wdata_o;
    logic        hold_o, jump_o;
    logic [31:0] jump_addr_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        jump;
        logic [31:0] jaddr;
    } exp_t;

    exp_t sb_q[$];

    excp_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ecall_i      (ecall_i),
        .ebreak_i     (ebreak_i),
        .mret_i       (mret_i),
        .inst_addr_i  (inst_addr_i),
`ifdef EXCP_IRQ_EN
        .irq_i        (irq_i),
`endif
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .mstatus_i    (mstatus_i),
        .excp_we_o    (excp_we_o),
        .excp_waddr_o (excp_waddr_o),
        .excp_wdata_o (excp_wdata_o),
        .hold_o       (hold_o),
        .jump_o       (jump_o),
        .jump_addr_o  (jump_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t e_idle(input logic hold);
        exp_t e;
        e = '0;
        e.hold = hold;
        return e;
    endfunction

    function automatic exp_t e_wr(input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e = '0;
        e.hold = 1'b1; e.we = 1'b1; e.waddr = a; e.wdata = d;
        return e;
    endfunction

    function automatic exp_t e_jmp(input logic [31:0] a);
        exp_t e;
        e = '0;
        e.hold = 1'b1; e.jump = 1'b1; e.jaddr = a;
        return e;
    endfunction

    // Push expectation for the current cycle and advance to just after the next edge
    task automatic tick(input exp_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_trig();
        ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the scoreboard head
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("hold",  {63'd0, hold_o},       {63'd0, e.hold});
            chk("we",    {63'd0, excp_we_o},    {63'd0, e.we});
            chk("waddr", {52'd0, excp_waddr_o}, {52'd0, e.waddr});
            chk("wdata", {32'd0, excp_wdata_o}, {32'd0, e.wdata});
            chk("jump",  {63'd0, jump_o},       {63'd0, e.jump});
            chk("jaddr", {32'd0, jump_addr_o},  {32'd0, e.jaddr});
        end
    end

    initial begin
        rst_n = 1'b0; irq_i = 1'b0;
        clr_trig();
        inst_addr_i = 32'h0; mtvec_i = 32'h0; mepc_i = 32'h0; mstatus_i = 32'h0;
        ecall_i = 1'b1;  // trigger present during reset must not leak out
        #12;
        chk("rst_hold",  {63'd0, hold_o},      64'd0);
        chk("rst_we",    {63'd0, excp_we_o},   64'd0);
        chk("rst_jump",  {63'd0, jump_o},      64'd0);
        chk("rst_wdata", {32'd0, excp_wdata_o}, 64'd0);
        @(posedge clk); #1;

        // Basic ecall, released from reset in the same cycle
        rst_n = 1'b1;
        ecall_i = 1'b1; inst_addr_i = 32'h0000_0100; mtvec_i = 32'h0000_0200; mstatus_i = 32'h8;
        tick(e_idle(1'b1));
        clr_trig();
        tick(e_wr(12'h341, 32'h0000_0100));
        tick(e_wr(12'h342, 32'd11));
        tick(e_wr(12'h300, 32'h0000_1880));
        tick(e_jmp(32'h0000_0200));
        tick(e_idle(1'b0));

        // mret
        mret_i = 1'b1; mstatus_i = 32'h80; mepc_i = 32'h0000_0104;
        tick(e_idle(1'b1));
        clr_trig();
        tick(e_wr(12'h300, 32'h0000_0088));
        tick(e_jmp(32'h0000_0104));
        tick(e_idle(1'b0));

        // ecall+ebreak+mret together: ecall wins; ebreak during W_MCAUSE ignored
        ecall_i = 1'b1; ebreak_i = 1'b1; mret_i = 1'b1;
        inst_addr_i = 32'h0000_0A40; mstatus_i = 32'h0; mtvec_i = 32'h0000_0300;
        tick(e_idle(1'b1));
        clr_trig();
        inst_addr_i = 32'h0000_0BBC;
        tick(e_wr(12'h341, 32'h0000_0A40));
        ebreak_i = 1'b1;
        tick(e_wr(12'h342, 32'd11));
        ebreak_i = 1'b0;
        tick(e_wr(12'h300, 32'h0000_1800));
        tick(e_jmp(32'h0000_0300));
        tick(e_idle(1'b0));
        tick(e_idle(1'b0));

        // ebreak alone, unaligned mtvec, mstatus with other bits set
        ebreak_i = 1'b1; inst_addr_i = 32'hDEAD_BEE0; mtvec_i = 32'h0000_0403;
        mstatus_i = 32'hF000_0008;
        tick(e_idle(1'b1));
        clr_trig();
        tick(e_wr(12'h341, 32'hDEAD_BEE0));
        tick(e_wr(12'h342, 32'd3));
        tick(e_wr(12'h300, 32'hF000_1880));
        mret_i = 1'b1;  // trigger arriving during JUMP is ignored
        tick(e_jmp(32'h0000_0400));
        clr_trig();
        tick(e_idle(1'b0));

`ifdef EXCP_IRQ_EN
        // irq masked by MIE=0, then taken once enabled; it beats ecall
        irq_i = 1'b1; mstatus_i = 32'h0; inst_addr_i = 32'h0000_0500; mtvec_i = 32'h0000_0600;
        tick(e_idle(1'b0));
        tick(e_idle(1'b0));
        mstatus_i = 32'h8; ecall_i = 1'b1;
        tick(e_idle(1'b1));
        clr_trig();
        tick(e_wr(12'h341, 32'h0000_0500));
        tick(e_wr(12'h342, 32'h8000_000B));
        tick(e_wr(12'h300, 32'h0000_1880));
        irq_i = 1'b0;
        tick(e_jmp(32'h0000_0600));
        tick(e_idle(1'b0));
`endif

        // Reset asserted mid-sequence during W_MCAUSE
        ecall_i = 1'b1; inst_addr_i = 32'h0000_0700; mtvec_i = 32'h0000_0800; mstatus_i = 32'h8;
        tick(e_idle(1'b1));
        clr_trig();
        tick(e_wr(12'h341, 32'h0000_0700));
        #2;
        chk("mid_we_before", {63'd0, excp_we_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we",    {63'd0, excp_we_o},    64'd0);
        chk("arst_waddr", {52'd0, excp_waddr_o}, 64'd0);
        chk("arst_wdata", {32'd0, excp_wdata_o}, 64'd0);
        chk("arst_hold",  {63'd0, hold_o},       64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_we",   {63'd0, excp_we_o}, 64'd0);
            chk("rst_no_jump", {63'd0, jump_o},    64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ecall_i = 1'b1; inst_addr_i = 32'h0000_0900;
        tick(e_idle(1'b1));
        clr_trig();
        tick(e_wr(12'h341, 32'h0000_0900));
        tick(e_wr(12'h342, 32'd11));
        tick(e_wr(12'h300, 32'h0000_1880));
        tick(e_jmp(32'h0000_0800));
        tick(e_idle(1'b0));

        @(posedge clk); #1;
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
